// File: rtl/button_bank_if.sv
// Button bank signal bundle: raw button levels in, debounced level and
// event pulses out. The board side (master) drives btn_in; the button
// bank (slave) drives everything else.
interface button_bank_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] repeat_pulse;
    logic             any_press;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  any_press
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output any_press
    );
endinterface

// File: rtl/button_bank.sv
// Multi-channel pushbutton front end. Each channel independently
// synchronises its raw input, debounces it with a commit counter, and
// turns the debounced level into press/release pulses plus long-press
// and auto-repeat pulses from a small per-channel hold FSM.
module button_bank #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic               clock,
    input  logic               reset_n,
    button_bank_if.slave       bus
);

    // Counter widths hold their terminal value; every counter is cleared
    // at its terminal count, so none can wrap.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } hold_state_t;

    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
    logic [N_BTN-1:0] long_v;
    logic [N_BTN-1:0] repeat_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;
        logic                   debounced;
        logic                   deb_d;
        logic [DW-1:0]          deb_cnt;
        hold_state_t            state;
        hold_state_t            state_nxt;
        logic [HW-1:0]          hold_cnt;
        logic [HW-1:0]          hold_cnt_nxt;
        logic [RW-1:0]          rpt_cnt;
        logic [RW-1:0]          rpt_cnt_nxt;
        logic                   press;
        logic                   long_evt;
        logic                   rpt_evt;

        // Synchroniser shift register for the asynchronous button level.
        // NOTE: the synchroniser flops are reset too, so a button held
        // through reset is seen as a fresh 0->1 edge after release.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
            end else begin
                // NOTE: non-blocking assignment keeps every flop sampling
                // the pre-edge value, so the chain shifts one stage per clock.
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in[i]};
            end
        end

        assign sync_out = sync_q[SYNC_STAGES-1];

        // Debounce: commit a new level only after DEBOUNCE_CYCLES
        // consecutive disagreeing samples; any agreement restarts the count.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                debounced <= 1'b0;
                deb_d     <= 1'b0;
                deb_cnt   <= '0;
            end else begin
                deb_d <= debounced;
                if (sync_out == debounced) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    debounced <= sync_out;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end
        end

        assign press = debounced & ~deb_d;

        // Hold FSM state and counter registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rpt_cnt  <= '0;
            end else begin
                state    <= state_nxt;
                hold_cnt <= hold_cnt_nxt;
                rpt_cnt  <= rpt_cnt_nxt;
            end
        end

        // Hold FSM next state and pulses; a released button wins over any
        // long or repeat pulse due in the same cycle.
        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path through the case can leave a value held (no latches).
            state_nxt    = state;
            hold_cnt_nxt = hold_cnt;
            rpt_cnt_nxt  = rpt_cnt;
            long_evt     = 1'b0;
            rpt_evt      = 1'b0;

            if (!debounced) begin
                state_nxt    = IDLE;
                hold_cnt_nxt = '0;
                rpt_cnt_nxt  = '0;
            end else if (press) begin
                state_nxt    = PRESSED;
                hold_cnt_nxt = '0;
                rpt_cnt_nxt  = '0;
            end else begin
                case (state)
                    PRESSED: begin
                        if (hold_cnt == HOLD_LAST) begin
                            long_evt     = 1'b1;
                            state_nxt    = HELD;
                            hold_cnt_nxt = '0;
                            rpt_cnt_nxt  = '0;
                        end else begin
                            hold_cnt_nxt = hold_cnt + HW'(1);
                        end
                    end
                    HELD: begin
                        if (REPEAT_EN != 0) begin
                            if (rpt_cnt == RPT_LAST) begin
                                rpt_evt     = 1'b1;
                                rpt_cnt_nxt = '0;
                            end else begin
                                rpt_cnt_nxt = rpt_cnt + RW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign level_v[i]   = debounced;
        assign press_v[i]   = press;
        assign release_v[i] = ~debounced & deb_d;
        assign long_v[i]    = long_evt;
        assign repeat_v[i]  = rpt_evt;
    end

    assign bus.btn_level     = level_v;
    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.long_pulse    = long_v;
    assign bus.repeat_pulse  = repeat_v;
    assign bus.any_press     = |press_v;

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: two instances (auto-repeat on / off) share the
// same button stimulus. Stimulus pushes expected pulse events into a
// cycle-ordered scoreboard queue; a monitor pops and compares whenever an
// instance shows any pulse.
`timescale 1ns/1ps
module tb_button_bank;

    localparam int N    = 2;
    localparam int SYNC = 3;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int RPT  = 8;
    // Input driven at the negedge of cycle c is sampled at edge c+1; the
    // level commits after edge (c+1)+SYNC+DEB-1, so the pulse is seen at c+7.
    localparam int LAT  = SYNC + DEB;

    localparam int K_PR = 0;
    localparam int K_RL = 1;
    localparam int K_LG = 2;
    localparam int K_RP = 3;

    typedef struct {
        int         d;
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic [1:0] lg;
        logic [1:0] rp;
    } ev_t;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn     = '0;
    int           cyc     = 0;
    int           compared = 0;
    int           failed   = 0;
    ev_t          sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    button_bank_if #(.N_BTN(N)) bif_rep ();
    button_bank_if #(.N_BTN(N)) bif_nor ();

    assign bif_rep.btn_in = btn;
    assign bif_nor.btn_in = btn;

    button_bank #(
        .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_EN(1), .REPEAT_CYCLES(RPT)
    ) u_rep (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif_rep.slave)
    );

    button_bank #(
        .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_EN(0), .REPEAT_CYCLES(RPT)
    ) u_nor (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif_nor.slave)
    );

    // Add an expected pulse for instance d at cycle c, merging events that
    // share a cycle and keeping the queue sorted by cycle.
    function automatic void push(input int d, input int c, input int kind, input logic [1:0] m);
        ev_t e;
        int  pos;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].d == d && sb[i].cyc == c) begin
                case (kind)
                    K_PR:    sb[i].pr |= m;
                    K_RL:    sb[i].rl |= m;
                    K_LG:    sb[i].lg |= m;
                    default: sb[i].rp |= m;
                endcase
                return;
            end
        end
        e.d = d; e.cyc = c; e.pr = '0; e.rl = '0; e.lg = '0; e.rp = '0;
        case (kind)
            K_PR:    e.pr = m;
            K_RL:    e.rl = m;
            K_LG:    e.lg = m;
            default: e.rp = m;
        endcase
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endfunction

    function automatic void push_both(input int c, input int kind, input logic [1:0] m);
        push(0, c, kind, m);
        push(1, c, kind, m);
    endfunction

    function automatic int first_idx(input int d);
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].d == d) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for one instance: retire expected events that went by unseen,
    // then match any visible pulse against the head of the queue.
    task automatic mon(input int d, input logic [1:0] pr, input logic [1:0] rl,
                       input logic [1:0] lg, input logic [1:0] rp, input logic anyp);
        int   idx;
        logic seen;
        seen = ((pr | rl | lg | rp) != 2'b00) || anyp;
        idx  = first_idx(d);
        while (idx >= 0 && sb[idx].cyc < cyc) begin
            compared++;
            failed++;
            $display("FAIL missed_pulse dut%0d: nothing at cycle %0d, expected pr=%b rl=%b lg=%b rp=%b",
                     d, sb[idx].cyc, sb[idx].pr, sb[idx].rl, sb[idx].lg, sb[idx].rp);
            sb.delete(idx);
            idx = first_idx(d);
        end
        if (seen) begin
            compared++;
            if (idx >= 0 && sb[idx].cyc == cyc) begin
                if (pr !== sb[idx].pr || rl !== sb[idx].rl || lg !== sb[idx].lg ||
                    rp !== sb[idx].rp || anyp !== (|sb[idx].pr)) begin
                    failed++;
                    $display("FAIL pulse_event dut%0d cyc %0d: got pr=%b rl=%b lg=%b rp=%b any=%b, expected pr=%b rl=%b lg=%b rp=%b any=%b",
                             d, cyc, pr, rl, lg, rp, anyp,
                             sb[idx].pr, sb[idx].rl, sb[idx].lg, sb[idx].rp, |sb[idx].pr);
                end
                sb.delete(idx);
            end else begin
                failed++;
                $display("FAIL unexpected_pulse dut%0d cyc %0d: got pr=%b rl=%b lg=%b rp=%b any=%b, expected none",
                         d, cyc, pr, rl, lg, rp, anyp);
            end
        end
    endtask

    always @(negedge clock) begin
        mon(0, bif_rep.press_pulse, bif_rep.release_pulse, bif_rep.long_pulse,
            bif_rep.repeat_pulse, bif_rep.any_press);
        mon(1, bif_nor.press_pulse, bif_nor.release_pulse, bif_nor.long_pulse,
            bif_nor.repeat_pulse, bif_nor.any_press);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [15:0] outs_rep();
        return 16'({bif_rep.btn_level, bif_rep.press_pulse, bif_rep.release_pulse,
                    bif_rep.long_pulse, bif_rep.repeat_pulse, bif_rep.any_press});
    endfunction

    function automatic logic [15:0] outs_nor();
        return 16'({bif_nor.btn_level, bif_nor.press_pulse, bif_nor.release_pulse,
                    bif_nor.long_pulse, bif_nor.repeat_pulse, bif_nor.any_press});
    endfunction

    initial begin
        int c;
        int p;
        int r;

        // 1. Reset with both buttons held, then a fresh press on both.
        btn     = 2'b11;
        reset_n = 1'b0;
        tick(3);
        check("reset_outs_rep", outs_rep(), 16'h0);
        check("reset_outs_nor", outs_nor(), 16'h0);
        reset_n = 1'b1;
        c = cyc;
        push_both(c + LAT, K_PR, 2'b11);
        tick(1);
        check("first_cycle_outs_rep", outs_rep(), 16'h0);
        tick(LAT + 2);
        check("level_after_reset_rep", 16'(bif_rep.btn_level), 16'h3);
        check("level_after_reset_nor", 16'(bif_nor.btn_level), 16'h3);
        btn = 2'b00;
        push_both(cyc + LAT, K_RL, 2'b11);
        tick(15);
        check("level_released", 16'(bif_rep.btn_level), 16'h0);

        // 2. Glitches of 3 cycles never commit; a 4-cycle step does.
        for (int g = 0; g < 5; g++) begin
            btn[0] = 1'b1;
            tick(3);
            btn[0] = 1'b0;
            tick(3);
        end
        tick(6);
        check("glitch_level", 16'(bif_rep.btn_level), 16'h0);
        c = cyc;
        btn[0] = 1'b1;
        push_both(c + LAT, K_PR, 2'b01);
        tick(4);
        btn[0] = 1'b0;
        push_both(cyc + LAT, K_RL, 2'b01);
        tick(15);

        // 3. Short press: 10-cycle hold, no long or repeat.
        c = cyc;
        btn[0] = 1'b1;
        push_both(c + LAT, K_PR, 2'b01);
        tick(LAT + 2);
        check("short_level", 16'(bif_rep.btn_level), 16'h1);
        tick(10 - LAT - 2);
        btn[0] = 1'b0;
        push_both(cyc + LAT, K_RL, 2'b01);
        tick(15);

        // 4/5. 60-cycle hold: long at +20, repeats at +28..+52 on the
        // repeating instance; the +60 repeat slot is the release cycle.
        c = cyc;
        p = c + LAT;
        btn[0] = 1'b1;
        push_both(p, K_PR, 2'b01);
        push_both(p + LONG, K_LG, 2'b01);
        for (int t = p + LONG + RPT; t < p + 60; t += RPT)
            push(0, t, K_RP, 2'b01);
        tick(60);
        btn[0] = 1'b0;
        push_both(cyc + LAT, K_RL, 2'b01);
        tick(20);

        // 6. Staggered presses, reset mid-hold, then fresh timing on both.
        c = cyc;
        btn[0] = 1'b1;
        push_both(c + LAT, K_PR, 2'b01);
        tick(15);
        btn[1] = 1'b1;
        push_both(cyc + LAT, K_PR, 2'b10);
        tick(10);
        reset_n = 1'b0;
        #1;
        check("midhold_reset_rep", outs_rep(), 16'h0);
        check("midhold_reset_nor", outs_nor(), 16'h0);
        tick(1);
        reset_n = 1'b1;
        r = cyc;
        push_both(r + LAT, K_PR, 2'b11);
        push_both(r + LAT + LONG, K_LG, 2'b11);
        push(0, r + LAT + LONG + RPT, K_RP, 2'b11);
        push(0, r + LAT + LONG + 2 * RPT, K_RP, 2'b11);
        tick(40);
        check("rehold_level_nor", 16'(bif_nor.btn_level), 16'h3);
        btn = 2'b00;
        push_both(cyc + LAT, K_RL, 2'b11);
        tick(20);

        // Anything still queued was never produced.
        foreach (sb[i]) begin
            compared++;
            failed++;
            $display("FAIL leftover dut%0d: nothing at cycle %0d, expected pr=%b rl=%b lg=%b rp=%b",
                     sb[i].d, sb[i].cyc, sb[i].pr, sb[i].rl, sb[i].lg, sb[i].rp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
Multi-channel button front end and parametrised successor to the single-button debounce/one-pulse block. For each of N_BTN raw pushbutton inputs it provides synchronisation, counter-based debounce, press and release one-cycle pulses, long-press detection and optional auto-repeat. It sits between the board pushbuttons and the control FSMs, and all outputs are in the `clock` domain (100 MHz system clock).

Parameters:
N_BTN, 4, number of independent button channels (>=1)
SYNC_STAGES, 3, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 2_000_000, consecutive disagreeing cycles needed to commit a level change (20 ms @100 MHz; >=1)
LONG_CYCLES, 100_000_000, press_pulse-to-long_pulse distance in cycles (1 s; >=2)
REPEAT_EN, 1, 1 = auto-repeat after long press; 0 = no repeat
REPEAT_CYCLES, 20_000_000, repeat period in cycles (200 ms; >=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
btn_in  input  N_BTN  raw asynchronous button levels, 1 = pressed
btn_level  output  N_BTN  debounced level per channel
press_pulse  output  N_BTN  1-cycle pulse on debounced 0->1
release_pulse  output  N_BTN  1-cycle pulse on debounced 1->0
long_pulse  output  N_BTN  1-cycle pulse when hold reaches LONG_CYCLES
repeat_pulse  output  N_BTN  1-cycle pulse every REPEAT_CYCLES after long_pulse
any_press  output  1  OR-reduction of press_pulse

Behaviour:
- Reset: async on reset_n low; all sync flops, debounced levels, delayed copies, counters = 0; FSMs = IDLE; all outputs 0 while reset is asserted and in the first cycle after release.
- Channels are fully independent. Each channel has its own SYNC_STAGES-deep shift register; sync_out is the last stage.
- Debounce per channel: if sync_out == debounced, cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1, debounced <= sync_out and cnt <= 0. Else cnt <= cnt+1. Counter width is $clog2(DEBOUNCE_CYCLES+1) and never wraps.
- Glitches: any return to agreement before commit clears cnt. Disagreement runs shorter than DEBOUNCE_CYCLES never change btn_level.
- Latency: a clean btn_in step sampled at edge k makes btn_level change after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- btn_level = debounced. deb_d is debounced delayed 1 cycle (reset 0).
- press_pulse = debounced & ~deb_d. release_pulse = ~debounced & deb_d. Each is exactly 1 cycle per committed edge.
- Hold FSM per channel, states IDLE, PRESSED, HELD:
  - IDLE: press_pulse -> PRESSED, hold_cnt <= 0.
  - PRESSED: hold_cnt++ each cycle. long_pulse = (hold_cnt == LONG_CYCLES-1) & debounced, so it fires exactly LONG_CYCLES cycles after the press_pulse cycle. On that cycle -> HELD, rpt_cnt <= 0.
  - HELD: if REPEAT_EN, rpt_cnt++ and repeat_pulse = (rpt_cnt == REPEAT_CYCLES-1) & debounced, then rpt_cnt <= 0. Repeats fire at long_pulse + m*REPEAT_CYCLES for m >= 1. If REPEAT_EN = 0, HELD is idle and repeat_pulse stays 0.
  - Any state with debounced = 0 -> IDLE, counters cleared. Release has priority: a long or repeat pulse scheduled for the release cycle is suppressed.
- Simultaneous events on different channels produce simultaneous pulses; any_press is combinational OR.
- Reset mid-operation: everything clears immediately. If the button is still held after reset release, a fresh press_pulse appears after normal latency; no long/repeat carry-over.
- Counters saturate by construction (cleared at terminal count); no overflow possible.

Test Plan:
(Bench params unless noted: N_BTN=2, SYNC_STAGES=3, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1.)
1. Reset: hold reset_n=0 with btn_in=2'b11, release -> all outputs 0 during reset. press_pulse[1:0]=2'b11 and any_press=1 exactly at edge 6 after release (SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles); btn_level=11 thereafter.
2. Glitch rejection: ch0 btn_in high for 3 cycles then low, repeated 5 times -> btn_level[0], press_pulse[0] and release_pulse[0] stay 0. Next, a 4-cycle-stable step (after sync) -> exactly one press_pulse[0].
3. Short press: ch0 held 10 cycles after commit, then released -> one press_pulse, one release_pulse 10 cycles later (stable input), no long_pulse or repeat_pulse.
4. Long + repeat: ch0 held 60 cycles -> long_pulse 20 cycles after press_pulse; repeat_pulse at +28, +36, +44, ... relative to press_pulse; release_pulse on release. No pulse on the release cycle even if it coincides with a repeat slot.
5. REPEAT_EN=0 with a 60-cycle hold -> exactly one long_pulse, zero repeat_pulse.
6. Independence/reset mid-hold: ch0 pressed 15 cycles before ch1; assert reset_n for 1 cycle mid-hold -> no long_pulse. After release, fresh press_pulses on both channels with latency 6 and new long timing measured from them.
